// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the pending-interrupt encoder.
package irq_pkg;

  localparam int N_SRC = 11;
  localparam int ID_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Decodes a source index into a per-source bit vector; out-of-range ids give zero.
  function automatic logic [N_SRC-1:0] src_onehot(input logic [ID_W-1:0] id);
    src_onehot = '0;
    for (int i = 0; i < N_SRC; i++)
      if (id == ID_W'(i)) src_onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority winner select: lowest set index wins.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [N_SRC-1:0] i_req,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan high to low so the last hit (lowest index) sticks.
    for (int i = N_SRC - 1; i >= 0; i--)
      if (i_req[i]) o_idx = ID_W'(i);
  end

endmodule

// File: rtl/irq_pending_encoder.sv
// Interrupt pending register with edge/level sources, priority select and
// a non-nesting IDLE/REQ/SERVICE handshake toward the CPU.
module irq_pending_encoder
  import irq_pkg::*;
#(
  parameter logic [N_SRC-1:0] POLARITY_MASK = 11'h000,
  parameter logic [N_SRC-1:0] EDGE_MASK     = 11'h7FF
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [N_SRC-1:0] Irq_In,
  input  logic [N_SRC-1:0] Irq_Mask,
  input  logic             Int_En,
  input  logic             Ack,
  input  logic             Eret,
  output logic             Irq_Req,
  output logic [ID_W-1:0]  Irq_Id,
  output logic             Irq_Active,
  output logic [N_SRC-1:0] Pending
);

  logic [N_SRC-1:0] r_e;
  logic [N_SRC-1:0] r_eq;
  logic [N_SRC-1:0] r_pend;
  irq_state_e       r_state;
  logic [ID_W-1:0]  r_id;

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_pend;
  logic [N_SRC-1:0] w_cand;
  logic             w_cand_vld;
  logic [ID_W-1:0]  w_win;
  irq_state_e       w_state_nxt;
  logic [ID_W-1:0]  w_id_nxt;
  logic             w_ack_ok;

  // Input stage then one more stage for edge history: r_e is the registered e.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_e  <= '0;
      r_eq <= '0;
    end else begin
      r_e  <= Irq_In ^ POLARITY_MASK;
      r_eq <= r_e;
    end
  end

  assign w_edge = r_e & ~r_eq;
  assign w_clr  = w_ack_ok ? (src_onehot(r_id) & EDGE_MASK) : '0;

  // A new edge in the clearing cycle wins over the clear.
  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    if (EDGE_MASK[g]) begin : g_edge
      assign w_pend_nxt[g] = w_edge[g] | (r_pend[g] & ~w_clr[g]);
      assign w_pend[g]     = r_pend[g];
    end else begin : g_level
      assign w_pend_nxt[g] = 1'b0;
      assign w_pend[g]     = r_e[g];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_pend <= '0;
    else          r_pend <= w_pend_nxt;
  end

  assign w_cand = w_pend & Irq_Mask;

  irq_prio_enc u_prio (
    .i_req   (w_cand),
    .o_valid (w_cand_vld),
    .o_idx   (w_win)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // Id is latched only on IDLE->REQ and frozen until the next request.
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_ack_ok    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Int_En && w_cand_vld) begin
          w_state_nxt = ST_REQ;
          w_id_nxt    = w_win;
        end
      end
      ST_REQ: begin
        if (Ack) begin
          w_state_nxt = ST_SERVICE;
          w_ack_ok    = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (Eret) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign Irq_Req    = (r_state == ST_REQ);
  assign Irq_Active = (r_state == ST_SERVICE);
  assign Irq_Id     = r_id;
  assign Pending    = w_pend;

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Scoreboard bench: expected ids queued at stimulus, popped when a request appears.
module tb_irq_pending_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] irq_in, mask, l_in, l_mask;
  logic        int_en, ack, eret, l_en, l_ack, l_eret;
  logic        o_req, o_act, l_req, l_act;
  logic [3:0]  o_id, l_id;
  logic [10:0] o_pend, l_pend;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  irq_pending_encoder u_dut (
    .Clock(clk), .Reset_n(rst_n), .Irq_In(irq_in), .Irq_Mask(mask),
    .Int_En(int_en), .Ack(ack), .Eret(eret), .Irq_Req(o_req),
    .Irq_Id(o_id), .Irq_Active(o_act), .Pending(o_pend)
  );

  irq_pending_encoder #(.POLARITY_MASK(11'h001), .EDGE_MASK(11'h7FE)) u_lvl (
    .Clock(clk), .Reset_n(rst_n), .Irq_In(l_in), .Irq_Mask(l_mask),
    .Int_En(l_en), .Ack(l_ack), .Eret(l_eret), .Irq_Req(l_req),
    .Irq_Id(l_id), .Irq_Active(l_act), .Pending(l_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_ack(input bit lvl);
    if (lvl) l_ack = 1'b1; else ack = 1'b1;
    step(1);
    l_ack = 1'b0; ack = 1'b0;
  endtask

  task automatic do_eret(input bit lvl);
    if (lvl) l_eret = 1'b1; else eret = 1'b1;
    step(1);
    l_eret = 1'b0; eret = 1'b0;
  endtask

  // Waits (bounded) for a request, then checks it against the scoreboard head.
  task automatic wait_req(input string tag, input bit lvl, input int exp_lat);
    int   n;
    logic req;
    n   = 0;
    req = lvl ? l_req : o_req;
    while (!req && n < 20) begin
      step(1);
      n++;
      req = lvl ? l_req : o_req;
    end
    chk({tag, "_req"}, 32'(req), 32'd1);
    if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
    else chk({tag, "_id"}, 32'(lvl ? l_id : o_id), 32'(exp_q.pop_front()));
    if (exp_lat > 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; irq_in = '0; mask = 11'h7FF; int_en = 1'b1; ack = 1'b0; eret = 1'b0;
    l_in = 11'h001; l_mask = 11'h7FF; l_en = 1'b1; l_ack = 1'b0; l_eret = 1'b0;
    step(2);
    chk("rst_req", 32'(o_req), 32'd0);
    chk("rst_id", 32'(o_id), 32'd0);
    chk("rst_act", 32'(o_act), 32'd0);
    chk("rst_pend", 32'(o_pend), 32'd0);
    rst_n = 1'b1;
    step(2);

    // single edge source, 3-cycle latency, ack clears, eret returns to idle
    irq_in[2] = 1'b1; exp_q.push_back(2);
    wait_req("t1", 1'b0, 3);
    do_ack(1'b0);
    chk("t1_pend_clr", 32'(o_pend), 32'd0);
    chk("t1_act", 32'(o_act), 32'd1);
    chk("t1_req_lo", 32'(o_req), 32'd0);
    do_eret(1'b0);
    step(3);
    chk("t1_idle_act", 32'(o_act), 32'd0);
    chk("t1_idle_req", 32'(o_req), 32'd0);
    irq_in = '0; step(2);

    // simultaneous sources: lowest index first, other waits in pending
    irq_in = 11'h012; exp_q.push_back(1); exp_q.push_back(4);
    wait_req("t2a", 1'b0, 3);
    chk("t2_pend_both", 32'(o_pend), 32'h012);
    do_ack(1'b0); do_eret(1'b0);
    wait_req("t2b", 1'b0, 0);
    do_ack(1'b0); do_eret(1'b0);
    irq_in = '0; step(2);

    // new edge in the ack cycle keeps the bit
    irq_in[2] = 1'b1; exp_q.push_back(2);
    wait_req("t3a", 1'b0, 3);
    irq_in[2] = 1'b0; step(1);
    irq_in[2] = 1'b1; step(1);
    do_ack(1'b0);
    chk("t3_set_wins", 32'(o_pend[2]), 32'd1);
    chk("t3_act", 32'(o_act), 32'd1);
    do_eret(1'b0);
    exp_q.push_back(2);
    wait_req("t3b", 1'b0, 0);
    do_ack(1'b0);
    chk("t3_pend_clr", 32'(o_pend), 32'd0);
    do_eret(1'b0);
    irq_in = '0; step(2);

    // global enable gating, frozen id in REQ, ack/eret corner cases
    int_en = 1'b0; irq_in[0] = 1'b1;
    step(5);
    chk("t4_pend_dis", 32'(o_pend), 32'h001);
    chk("t4_req_dis", 32'(o_req), 32'd0);
    exp_q.push_back(0); int_en = 1'b1;
    wait_req("t4a", 1'b0, 1);
    mask = '0; irq_in[1] = 1'b1;
    step(4);
    chk("t4_hold_req", 32'(o_req), 32'd1);
    chk("t4_hold_id", 32'(o_id), 32'd0);
    do_eret(1'b0);
    chk("t4_eret_in_req", 32'(o_req), 32'd1);
    ack = 1'b1; eret = 1'b1; step(1); ack = 1'b0; eret = 1'b0;
    chk("t4_ack_eret_act", 32'(o_act), 32'd1);
    step(1);
    chk("t4_ack_eret_hold", 32'(o_act), 32'd1);
    do_eret(1'b0);
    step(3);
    chk("t4_masked_req", 32'(o_req), 32'd0);
    chk("t4_masked_pend", 32'(o_pend), 32'h002);
    do_ack(1'b0);
    chk("t4_ack_idle_act", 32'(o_act), 32'd0);
    chk("t4_ack_idle_pend", 32'(o_pend), 32'h002);
    mask = 11'h7FF; exp_q.push_back(1);
    wait_req("t4b", 1'b0, 0);
    do_ack(1'b0); do_eret(1'b0);
    irq_in = '0; step(2);

    // async reset mid-cycle in SERVICE; held sources relatch after release
    irq_in = 11'h048; exp_q.push_back(3);
    wait_req("t5a", 1'b0, 3);
    do_ack(1'b0);
    chk("t5_pend_svc", 32'(o_pend), 32'h040);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_act", 32'(o_act), 32'd0);
    chk("t5_rst_req", 32'(o_req), 32'd0);
    chk("t5_rst_id", 32'(o_id), 32'd0);
    chk("t5_rst_pend", 32'(o_pend), 32'd0);
    step(2);
    rst_n = 1'b1; exp_q.push_back(3); exp_q.push_back(6);
    wait_req("t5b", 1'b0, 3);
    do_ack(1'b0); do_eret(1'b0);
    wait_req("t5c", 1'b0, 0);
    do_ack(1'b0); do_eret(1'b0);
    irq_in = '0; step(2);

    // inverted level source: ack does not clear, re-request while asserted
    l_in[0] = 1'b0; step(1);
    chk("t6_lvl_pend", 32'(l_pend[0]), 32'd1);
    exp_q.push_back(0);
    wait_req("t6a", 1'b1, 0);
    do_ack(1'b1);
    chk("t6_ack_keeps", 32'(l_pend[0]), 32'd1);
    chk("t6_act", 32'(l_act), 32'd1);
    do_eret(1'b1);
    exp_q.push_back(0);
    wait_req("t6b", 1'b1, 0);
    do_ack(1'b1);
    l_in[0] = 1'b1;
    do_eret(1'b1);
    step(2);
    chk("t6_lvl_gone", 32'(l_pend[0]), 32'd0);
    chk("t6_no_req", 32'(l_req), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
